// File: rtl/packet_filter_pkg.sv
// Shared packet_filter definitions: set/clear priority encodings and the
// per-bit next-state rule used by the set/clear flag registers.
package packet_filter_pkg;

   localparam bit CLEAR_WINS     = 1'b1;
   localparam bit SET_WINS       = 1'b0;
   localparam int MAX_FLAG_WIDTH = 64;

   function automatic logic next_flag(input logic q, input logic s,
                                      input logic c, input logic clr_wins);
      if (s && c) return ~clr_wins;
      if (s)      return 1'b1;
      if (c)      return 1'b0;
      return q;
   endfunction

endpackage

// File: rtl/reg_set_clear_bit.sv
// One set/clear flag bit with registered 0->1 / 1->0 edge pulses.
module reg_set_clear_bit
   import packet_filter_pkg::*;
#(
   parameter bit CLEAR_PRIORITY = CLEAR_WINS,
   parameter bit RESET_VALUE    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic clear,
   output logic q,
   output logic rose,
   output logic fell
);

   logic r_q;
   logic r_rose;
   logic r_fell;
   logic w_next;

   assign w_next = next_flag(r_q, set, clear, CLEAR_PRIORITY);

   // Pulses compare next against current state, so a reset load never pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q    <= RESET_VALUE;
         r_rose <= 1'b0;
         r_fell <= 1'b0;
      end else begin
         r_q    <= w_next;
         r_rose <= w_next & ~r_q;
         r_fell <= ~w_next & r_q;
      end
   end

   assign q    = r_q;
   assign rose = r_rose;
   assign fell = r_fell;

endmodule

// File: rtl/reg_set_clear.sv
// WIDTH independent set/clear flags with rose/fell pulses.
// Define REG_SET_CLEAR_ASSERT_EN to compile in parameter checks and assertions.
module reg_set_clear
   import packet_filter_pkg::*;
#(
   parameter int               WIDTH          = 1,
   parameter int               CLEAR_PRIORITY = int'(CLEAR_WINS),
   parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] clear,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rose,
   output logic [WIDTH-1:0] fell
);

   localparam bit CLR_WINS = (CLEAR_PRIORITY != 0);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      reg_set_clear_bit #(
         .CLEAR_PRIORITY (CLR_WINS),
         .RESET_VALUE    (RESET_VALUE[i])
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .set   (set[i]),
         .clear (clear[i]),
         .q     (q[i]),
         .rose  (rose[i]),
         .fell  (fell[i])
      );
   end

`ifdef REG_SET_CLEAR_ASSERT_EN
   if (WIDTH < 1 || WIDTH > MAX_FLAG_WIDTH) begin : g_bad_width
      $error("reg_set_clear: WIDTH %0d outside 1..%0d", WIDTH, MAX_FLAG_WIDTH);
   end
   if (CLEAR_PRIORITY != int'(CLEAR_WINS) && CLEAR_PRIORITY != int'(SET_WINS)) begin : g_bad_prio
      $error("reg_set_clear: CLEAR_PRIORITY %0d must be 0 or 1", CLEAR_PRIORITY);
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chk
      a_set_only: assert property (@(posedge clk) disable iff (reset)
         (set[i] && !clear[i]) |=> q[i]);
      a_clr_only: assert property (@(posedge clk) disable iff (reset)
         (clear[i] && !set[i]) |=> !q[i]);
      a_hold: assert property (@(posedge clk) disable iff (reset)
         (!set[i] && !clear[i]) |=> $stable(q[i]));
      a_excl: assert property (@(posedge clk) disable iff (reset)
         !(rose[i] && fell[i]));
   end
`endif

endmodule

// File: tb/tb_reg_set_clear.sv
// Directed bench for reg_set_clear: three configurations checked every cycle
// against a vector-level model, plus hand-computed literal expectations.
module tb_reg_set_clear;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // a: WIDTH=8 clear-wins, b: WIDTH=1 set-wins, c: WIDTH=4 reset value 1010
   logic [7:0] sa, ca, qa, ra, fa;
   logic       sb, cb, qb, rb, fb;
   logic [3:0] sc, cc, qc, rc, fc;

   reg_set_clear #(.WIDTH(8), .CLEAR_PRIORITY(1), .RESET_VALUE(8'h00)) u_a (
      .clk(clk), .reset(reset), .set(sa), .clear(ca), .q(qa), .rose(ra), .fell(fa));
   reg_set_clear #(.WIDTH(1), .CLEAR_PRIORITY(0), .RESET_VALUE(1'b0)) u_b (
      .clk(clk), .reset(reset), .set(sb), .clear(cb), .q(qb), .rose(rb), .fell(fb));
   reg_set_clear #(.WIDTH(4), .CLEAR_PRIORITY(1), .RESET_VALUE(4'b1010)) u_c (
      .clk(clk), .reset(reset), .set(sc), .clear(cc), .q(qc), .rose(rc), .fell(fc));

   int errs   = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Clear-wins: set ORs in, clear masks out last. Set-wins: the reverse.
   function automatic logic [7:0] nxt(input logic [7:0] q, input logic [7:0] s,
                                      input logic [7:0] c, input bit clr_wins);
      return clr_wins ? ((q | s) & ~c) : ((q & ~c) | s);
   endfunction

   logic [7:0] ma_q, ma_r, ma_f;
   logic       mb_q, mb_r, mb_f;
   logic [3:0] mc_q, mc_r, mc_f;

   always @(posedge clk) begin : model
      logic [7:0] n;
      if (reset) begin
         ma_q = 8'h00;   ma_r = '0; ma_f = '0;
         mb_q = 1'b0;    mb_r = '0; mb_f = '0;
         mc_q = 4'b1010; mc_r = '0; mc_f = '0;
      end else begin
         n = nxt(ma_q, sa, ca, 1'b1);
         ma_r = n & ~ma_q; ma_f = ma_q & ~n; ma_q = n;
         n = nxt({7'b0, mb_q}, {7'b0, sb}, {7'b0, cb}, 1'b0);
         mb_r = n[0] & ~mb_q; mb_f = mb_q & ~n[0]; mb_q = n[0];
         n = nxt({4'b0, mc_q}, {4'b0, sc}, {4'b0, cc}, 1'b1);
         mc_r = n[3:0] & ~mc_q; mc_f = mc_q & ~n[3:0]; mc_q = n[3:0];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc.a.q",    qa, ma_q);
         chk("cyc.a.rose", ra, ma_r);
         chk("cyc.a.fell", fa, ma_f);
         chk("cyc.b.q",    {7'b0, qb}, {7'b0, mb_q});
         chk("cyc.b.rose", {7'b0, rb}, {7'b0, mb_r});
         chk("cyc.b.fell", {7'b0, fb}, {7'b0, mb_f});
         chk("cyc.c.q",    {4'b0, qc}, {4'b0, mc_q});
         chk("cyc.c.rose", {4'b0, rc}, {4'b0, mc_r});
         chk("cyc.c.fell", {4'b0, fc}, {4'b0, mc_f});
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      sa = '0; ca = '0; sb = 1'b0; cb = 1'b0; sc = '0; cc = '0;
      tick(); tick();
      chk("rst.a.q",    qa, 8'h00);
      chk("rst.a.rose", ra, 8'h00);
      chk("rst.c.q",    {4'b0, qc}, 8'h0A);
      chk("rst.c.fell", {4'b0, fc}, 8'h00);
      chk_en = 1'b1;

      // set pulse then idle
      reset = 1'b0; sa = 8'h01; tick();
      chk("seq.q", qa, 8'h01);
      chk("seq.rose", ra, 8'h01);
      sa = 8'h00; tick(); tick(); tick();
      chk("idle.q", qa, 8'h01);
      chk("idle.rose", ra, 8'h00);

      // clear, then redundant clear
      ca = 8'h01; tick();
      chk("clr.q", qa, 8'h00);
      chk("clr.fell", fa, 8'h01);
      tick();
      chk("clr2.q", qa, 8'h00);
      chk("clr2.fell", fa, 8'h00);
      ca = 8'h00;

      // simultaneous set+clear held 5 cycles, both priorities
      sa = 8'h01; tick();
      ca = 8'h01; sb = 1'b1; cb = 1'b1; tick();
      chk("both.cw.q", qa, 8'h00);
      chk("both.cw.fell", fa, 8'h01);
      chk("both.sw.q", {7'b0, qb}, 8'h01);
      chk("both.sw.rose", {7'b0, rb}, 8'h01);
      repeat (4) tick();
      chk("hold.cw.q", qa, 8'h00);
      chk("hold.cw.fell", fa, 8'h00);
      chk("hold.sw.q", {7'b0, qb}, 8'h01);
      chk("hold.sw.rose", {7'b0, rb}, 8'h00);

      // bit independence from q=AA
      sa = 8'hAA; ca = 8'h55; sb = 1'b0; cb = 1'b0; tick();
      chk("ind.pre.q", qa, 8'hAA);
      sa = 8'h0F; ca = 8'hF0; tick();
      chk("ind.q", qa, 8'h0F);
      chk("ind.rose", ra, 8'h05);
      chk("ind.fell", fa, 8'hA0);

      // mid-operation reset with X on inputs
      sa = 8'h00; ca = 8'h00; sc = 4'b0101; tick();
      chk("mid.q", {4'b0, qc}, 8'h0F);
      chk("mid.rose", {4'b0, rc}, 8'h05);
      reset = 1'b1; sc = 4'b1111; sb = 1'bx; cb = 1'bx; tick();
      chk("mrst.c.q", {4'b0, qc}, 8'h0A);
      chk("mrst.c.rose", {4'b0, rc}, 8'h00);
      chk("mrst.c.fell", {4'b0, fc}, 8'h00);
      chk("mrst.a.fell", fa, 8'h00);
      reset = 1'b0; sb = 1'b0; cb = 1'b0; sc = 4'b0001; tick();
      chk("post.q", {4'b0, qc}, 8'h0B);
      chk("post.rose", {4'b0, rc}, 8'h01);
      sc = 4'b0000;

      // frame-drop pattern on a[0]
      for (int cyc = 0; cyc < 18; cyc++) begin
         sa = (cyc == 3 || cyc == 15) ? 8'h01 : 8'h00;
         ca = (cyc == 10 || cyc == 15) ? 8'h01 : 8'h00;
         tick();
         chk("frame.q", {7'b0, qa[0]}, (cyc >= 3 && cyc < 10) ? 8'h01 : 8'h00);
      end
      sa = 8'h00; ca = 8'h00; tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
